dmem_wait_responder: RTL and testbench

//  Data-memory responder on the MEM-stage side of the data-memory interface: accepts one

---
 rtl/dmem_wait_responder.sv | 139 +++++++++++++
 tb/tb_dmem_wait_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with WAIT_STATES cycles of latency and a pipeline stall.
// Optional per-word even parity is enabled by defining DMEM_PARITY_EN.
module dmem_wait_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  inj_par_flip,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  stall,
  output logic                  parity_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]            cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  assign accept     = (state == S_IDLE) && req_valid;
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign stall      = accept || (state == S_WAIT);

  // With zero wait states the commit happens on the accepting edge, so the
  // live request fields are used until they have been latched.
  assign acc_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign commit    = (state_nx == S_RESP) && (state != S_RESP);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = S_RESP;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_CNT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !acc_we) begin
        resp_rdata <= mem[acc_addr];
      end
    end
  end

  // Reset clears the whole array so unwritten words always read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && acc_we) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

`ifdef DMEM_PARITY_EN
  logic             lat_inj;
  logic             acc_inj;
  logic [DEPTH-1:0] par_mem;

  assign acc_inj = (state == S_IDLE) ? inj_par_flip : lat_inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_inj    <= 1'b0;
      par_mem    <= '0;
      parity_err <= 1'b0;
    end else begin
      if (accept) begin
        lat_inj <= inj_par_flip;
      end
      if (commit && acc_we) begin
        par_mem[acc_addr] <= (^acc_wdata) ^ acc_inj;
      end
      parity_err <= commit && !acc_we && (par_mem[acc_addr] != (^mem[acc_addr]));
    end
  end
`else
  logic unused_inj;
  assign unused_inj = inj_par_flip;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: one instance with two wait states,
// one with zero, selected through a shared request bundle.
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        inj_par_flip;
  logic        sel;

  logic        rv2, rv0;
  logic        ready2, ready0, rvalid2, rvalid0, stall2, stall0, perr2, perr0;
  logic [15:0] rdata2, rdata0;

  logic        o_ready, o_resp_valid, o_stall, o_perr;
  logic [15:0] o_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] rd;
  logic        pe;
  int          n;

  always #5 clk = ~clk;

  assign rv2 = req_valid & ~sel;
  assign rv0 = req_valid & sel;

  assign o_ready      = sel ? ready0  : ready2;
  assign o_resp_valid = sel ? rvalid0 : rvalid2;
  assign o_stall      = sel ? stall0  : stall2;
  assign o_perr       = sel ? perr0   : perr2;
  assign o_rdata      = sel ? rdata0  : rdata2;

  dmem_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inj_par_flip(inj_par_flip),
    .resp_valid(rvalid2), .resp_rdata(rdata2), .stall(stall2), .parity_err(perr2)
  );

  dmem_wait_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .inj_par_flip(inj_par_flip),
    .resp_valid(rvalid0), .resp_rdata(rdata0), .stall(stall0), .parity_err(perr0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge of an IDLE cycle, follows it to its
  // response and returns at the negedge of the following IDLE cycle.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                               input logic inj, input int exp_lat,
                               output logic [15:0] rdata, output logic perr);
    int lat;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    inj_par_flip = inj;
    #1;
    checkOutput("accept_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("accept_stall", {31'd0, o_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    inj_par_flip = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      checkOutput("wait_stall", {31'd0, o_stall}, 32'd1);
      checkOutput("wait_ready", {31'd0, o_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("resp_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("resp_stall", {31'd0, o_stall}, 32'd0);
    rdata = o_rdata;
    perr  = o_perr;
    @(negedge clk);
    checkOutput("resp_one_cycle", {31'd0, o_resp_valid}, 32'd0);
    checkOutput("idle_ready", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 8'h00;
    req_wdata    = 16'h0000;
    inj_par_flip = 1'b0;
    sel          = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ready2", {31'd0, ready2}, 32'd1);
    checkOutput("rst_rvalid2", {31'd0, rvalid2}, 32'd0);
    checkOutput("rst_stall2", {31'd0, stall2}, 32'd0);
    checkOutput("rst_rdata2", {16'd0, rdata2}, 32'h0);
    checkOutput("rst_perr2", {31'd0, perr2}, 32'd0);
    checkOutput("rst_ready0", {31'd0, ready0}, 32'd1);
    checkOutput("rst_rvalid0", {31'd0, rvalid0}, 32'd0);

    applyStimulus(1'b0, 8'h05, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("rst_load05", {16'd0, rd}, 32'h0000);

    applyStimulus(1'b1, 8'h10, 16'hBEEF, 1'b0, 3, rd, pe);
    checkOutput("store_perr", {31'd0, pe}, 32'd0);
    applyStimulus(1'b0, 8'h10, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("load10", {16'd0, rd}, 32'hBEEF);
    checkOutput("load10_perr", {31'd0, pe}, 32'd0);

    applyStimulus(1'b1, 8'h40, 16'h7777, 1'b0, 3, rd, pe);
    checkOutput("store_keeps_rdata", {16'd0, rd}, 32'hBEEF);
    applyStimulus(1'b1, 8'h11, 16'h1111, 1'b0, 3, rd, pe);
    applyStimulus(1'b0, 8'h11, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("load11", {16'd0, rd}, 32'h1111);

    // Request held high through WAIT with a different address must be ignored.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h10;
    @(posedge clk);
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 8'h40;
    req_wdata = 16'h9999;
    n = 0;
    while (!o_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_lat", 32'(n), 32'd2);
    checkOutput("held_rdata", {16'd0, o_rdata}, 32'hBEEF);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("held_idle_rvalid", {31'd0, o_resp_valid}, 32'd0);
    checkOutput("held_idle_stall", {31'd0, o_stall}, 32'd0);
    applyStimulus(1'b0, 8'h40, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("held_load40", {16'd0, rd}, 32'h7777);

    // Reset during the WAIT of a store abandons it.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstwait_stall", {31'd0, o_stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstwait_ready", {31'd0, o_ready}, 32'd1);
    checkOutput("rstwait_stall_lo", {31'd0, o_stall}, 32'd0);
    checkOutput("rstwait_rvalid", {31'd0, o_resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstwait_no_resp", {31'd0, o_resp_valid}, 32'd0);
    end
    applyStimulus(1'b0, 8'h20, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("rstwait_load20", {16'd0, rd}, 32'h0000);
    applyStimulus(1'b0, 8'h10, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("rst_cleared10", {16'd0, rd}, 32'h0000);

    applyStimulus(1'b1, 8'h30, 16'h0001, 1'b1, 3, rd, pe);
    checkOutput("par_store_perr", {31'd0, pe}, 32'd0);
    applyStimulus(1'b0, 8'h30, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("par_load30_data", {16'd0, rd}, 32'h0001);
`ifdef DMEM_PARITY_EN
    checkOutput("par_load30_err", {31'd0, pe}, 32'd1);
`else
    checkOutput("par_load30_err", {31'd0, pe}, 32'd0);
`endif
    applyStimulus(1'b1, 8'h31, 16'h0003, 1'b0, 3, rd, pe);
    applyStimulus(1'b0, 8'h31, 16'h0, 1'b0, 3, rd, pe);
    checkOutput("par_load31_data", {16'd0, rd}, 32'h0003);
    checkOutput("par_load31_err", {31'd0, pe}, 32'd0);

    // Zero-wait-state instance.
    sel = 1'b1;
    #1;
    applyStimulus(1'b1, 8'hFF, 16'h1234, 1'b0, 1, rd, pe);
    applyStimulus(1'b0, 8'hFF, 16'h0, 1'b0, 1, rd, pe);
    checkOutput("w0_loadFF", {16'd0, rd}, 32'h1234);
    applyStimulus(1'b0, 8'h00, 16'h0, 1'b0, 1, rd, pe);
    checkOutput("w0_load00", {16'd0, rd}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
